// File: rtl/axi_pkg.sv
`timescale 1ns/1ps
`default_nettype none
//============================================================================
// Package     : axi_pkg
// Description : Shared AXI3 encodings and FSM state types for the RAM
//               responder (burst types, response codes, read/write states).
// Revision    : 1.0 - initial release
//============================================================================
package axi_pkg;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10
    } burst_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_WAIT = 2'd1,
        R_DATA = 2'd2
    } rd_state_e;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } wr_state_e;

endpackage
`default_nettype wire

// File: rtl/axi_ram_responder_if.sv
`timescale 1ns/1ps
`default_nettype none
//============================================================================
// Interface   : axi_ram_responder_if
// Description : AXI3 bus bundle (AR/R/AW/W/B channels) between the CPU
//               bridge (master) and the RAM responder (slave).
// Revision    : 1.0 - initial release
//============================================================================
interface axi_ram_responder_if;

    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic [1:0]  arlock;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;

    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic [1:0]  awlock;
    logic [3:0]  awcache;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;

    logic [3:0]  wid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;

    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready,
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        output awready,
        input  wid, wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready
    );

    modport master (
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready,
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        input  awready,
        output wid, wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready
    );

endinterface
`default_nettype wire

// File: rtl/axi_addr_gen.sv
`timescale 1ns/1ps
`default_nettype none
//============================================================================
// Module      : axi_addr_gen
// Description : Combinational AXI3 next-beat address for FIXED/INCR/WRAP.
//               WRAP with a length other than 2/4/8/16 beats steps as INCR.
// Revision    : 1.0 - initial release
//============================================================================
module axi_addr_gen
    import axi_pkg::*;
(
    input  logic [31:0] addr_i,
    input  logic [2:0]  size_i,
    input  logic [7:0]  len_i,
    input  logic [1:0]  burst_i,
    output logic [31:0] next_addr_o
);

    logic [31:0] incr;
    logic [31:0] mask;
    logic        wrap_ok;

    // Step size, wrap window mask and next address for the current beat
    always_comb begin
        incr    = 32'd1 << size_i;
        mask    = ((32'(len_i) + 32'd1) << size_i) - 32'd1;
        wrap_ok = (len_i == 8'd1) || (len_i == 8'd3) || (len_i == 8'd7) || (len_i == 8'd15);
        case (burst_e'(burst_i))
            BURST_FIXED: next_addr_o = addr_i;
            BURST_WRAP:  next_addr_o = wrap_ok ? ((addr_i & ~mask) | ((addr_i + incr) & mask))
                                               : (addr_i + incr);
            default:     next_addr_o = addr_i + incr;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/axi_ram_responder.sv
`timescale 1ns/1ps
`default_nettype none
//============================================================================
// Module      : axi_ram_responder
// Description : AXI3 slave backed by a word-addressed RAM. Independent read
//               and write FSMs, one outstanding burst each, programmable
//               read latency. Memory survives reset.
// Revision    : 1.0 - initial release
//============================================================================
module axi_ram_responder
    import axi_pkg::*;
#(
    parameter int MEM_AW = 16,
    parameter int RD_LAT = 2
) (
    input  logic                clk,
    input  logic                reset,
    axi_ram_responder_if.slave  bus
);

    logic [31:0] mem_q [0:(1<<MEM_AW)-1];

    // Read channel state
    rd_state_e   rstate_q;
    logic [31:0] raddr_q, raddr_d;
    logic [7:0]  rlen_q, rbeats_q;
    logic [2:0]  rsize_q;
    logic [1:0]  rburst_q;
    logic [3:0]  rcnt_q;
    logic        arready_q, rvalid_q, rlast_q;
    logic [3:0]  rid_q;
    logic [31:0] rdata_q;
    logic [1:0]  rresp_q;

    // Write channel state
    wr_state_e   wstate_q;
    logic [31:0] waddr_q, waddr_d;
    logic [7:0]  wlen_q, wbeats_q;
    logic [2:0]  wsize_q;
    logic [1:0]  wburst_q;
    logic        awready_q, wready_q, bvalid_q, werr_q;
    logic [3:0]  bid_q;
    logic [1:0]  bresp_q;

    logic [MEM_AW-1:0] rd_idx, wr_idx;
    logic [31:0]       rd_word;
    logic              wr_en, wr_last, wr_err;

    axi_addr_gen u_rd_agen (
        .addr_i      (raddr_q),
        .size_i      (rsize_q),
        .len_i       (rlen_q),
        .burst_i     (rburst_q),
        .next_addr_o (raddr_d)
    );

    axi_addr_gen u_wr_agen (
        .addr_i      (waddr_q),
        .size_i      (wsize_q),
        .len_i       (wlen_q),
        .burst_i     (wburst_q),
        .next_addr_o (waddr_d)
    );

    assign wr_idx  = waddr_q[MEM_AW+1:2];
    assign wr_en   = !reset && (wstate_q == W_DATA) && wready_q && bus.wvalid;
    assign wr_last = (wbeats_q == 8'd0);
    assign wr_err  = werr_q || (bus.wlast != wr_last);

    // Word the next R beat will carry; a same-cycle write is merged in so the
    // beat presented next cycle already reflects it
    always_comb begin
        rd_idx = raddr_q[MEM_AW+1:2];
        case (rstate_q)
            R_IDLE:  rd_idx = bus.araddr[MEM_AW+1:2];
            R_DATA:  rd_idx = raddr_d[MEM_AW+1:2];
            default: ;
        endcase
        rd_word = mem_q[rd_idx];
        for (int b = 0; b < 4; b++) begin
            if (wr_en && (wr_idx == rd_idx) && bus.wstrb[b]) begin
                rd_word[8*b +: 8] = bus.wdata[8*b +: 8];
            end
        end
    end

    // Byte-lane writes into the RAM (not reset, contents persist)
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.wstrb[b]) begin
                    mem_q[wr_idx][8*b +: 8] <= bus.wdata[8*b +: 8];
                end
            end
        end
    end

    // Read FSM: accept AR, wait RD_LAT cycles, stream beats with registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            rstate_q  <= R_IDLE;
            raddr_q   <= '0;
            rlen_q    <= '0;
            rbeats_q  <= '0;
            rsize_q   <= '0;
            rburst_q  <= '0;
            rcnt_q    <= '0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rid_q     <= '0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
        end else begin
            case (rstate_q)
                R_IDLE: begin
                    arready_q <= 1'b1;
                    if (bus.arvalid && arready_q) begin
                        arready_q <= 1'b0;
                        raddr_q   <= bus.araddr;
                        rlen_q    <= bus.arlen;
                        rbeats_q  <= bus.arlen;
                        rsize_q   <= bus.arsize;
                        rburst_q  <= bus.arburst;
                        rid_q     <= bus.arid;
                        if (RD_LAT == 0) begin
                            rstate_q <= R_DATA;
                            rvalid_q <= 1'b1;
                            rdata_q  <= rd_word;
                            rlast_q  <= (bus.arlen == 8'd0);
                            rresp_q  <= RESP_OKAY;
                        end else begin
                            rcnt_q   <= 4'(RD_LAT - 1);
                            rstate_q <= R_WAIT;
                        end
                    end
                end
                R_WAIT: begin
                    if (rcnt_q == 4'd0) begin
                        rstate_q <= R_DATA;
                        rvalid_q <= 1'b1;
                        rdata_q  <= rd_word;
                        rlast_q  <= (rbeats_q == 8'd0);
                        rresp_q  <= RESP_OKAY;
                    end else begin
                        rcnt_q <= rcnt_q - 4'd1;
                    end
                end
                R_DATA: begin
                    if (rvalid_q && bus.rready) begin
                        if (rlast_q) begin
                            rvalid_q  <= 1'b0;
                            rlast_q   <= 1'b0;
                            arready_q <= 1'b1;
                            rstate_q  <= R_IDLE;
                        end else begin
                            raddr_q  <= raddr_d;
                            rbeats_q <= rbeats_q - 8'd1;
                            rdata_q  <= rd_word;
                            rlast_q  <= (rbeats_q == 8'd1);
                        end
                    end
                end
                default: rstate_q <= R_IDLE;
            endcase
        end
    end

    // Write FSM: accept AW, take awlen+1 beats (wlast only checked), then B
    always_ff @(posedge clk) begin
        if (reset) begin
            wstate_q  <= W_IDLE;
            waddr_q   <= '0;
            wlen_q    <= '0;
            wbeats_q  <= '0;
            wsize_q   <= '0;
            wburst_q  <= '0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            werr_q    <= 1'b0;
            bid_q     <= '0;
            bresp_q   <= RESP_OKAY;
        end else begin
            case (wstate_q)
                W_IDLE: begin
                    awready_q <= 1'b1;
                    if (bus.awvalid && awready_q) begin
                        awready_q <= 1'b0;
                        wready_q  <= 1'b1;
                        waddr_q   <= bus.awaddr;
                        wlen_q    <= bus.awlen;
                        wbeats_q  <= bus.awlen;
                        wsize_q   <= bus.awsize;
                        wburst_q  <= bus.awburst;
                        bid_q     <= bus.awid;
                        werr_q    <= 1'b0;
                        wstate_q  <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (wr_en) begin
                        if (wr_last) begin
                            wready_q <= 1'b0;
                            bvalid_q <= 1'b1;
                            bresp_q  <= wr_err ? RESP_SLVERR : RESP_OKAY;
                            wstate_q <= W_RESP;
                        end else begin
                            werr_q   <= wr_err;
                            waddr_q  <= waddr_d;
                            wbeats_q <= wbeats_q - 8'd1;
                        end
                    end
                end
                W_RESP: begin
                    if (bvalid_q && bus.bready) begin
                        bvalid_q  <= 1'b0;
                        awready_q <= 1'b1;
                        wstate_q  <= W_IDLE;
                    end
                end
                default: wstate_q <= W_IDLE;
            endcase
        end
    end

    assign bus.arready = arready_q;
    assign bus.rid     = rid_q;
    assign bus.rdata   = rdata_q;
    assign bus.rresp   = rresp_q;
    assign bus.rlast   = rlast_q;
    assign bus.rvalid  = rvalid_q;
    assign bus.awready = awready_q;
    assign bus.wready  = wready_q;
    assign bus.bid     = bid_q;
    assign bus.bresp   = bresp_q;
    assign bus.bvalid  = bvalid_q;

    // Sideband fields the responder does not act on
    logic unused_ok;
    assign unused_ok = ^{bus.arlock, bus.arcache, bus.arprot,
                         bus.awlock, bus.awcache, bus.awprot, bus.wid};

endmodule
`default_nettype wire

// File: tb/tb_axi_ram_responder.sv
`timescale 1ns/1ps
`default_nettype none
//============================================================================
// Module      : tb_axi_ram_responder
// Description : Directed self-checking bench for axi_ram_responder.
// Revision    : 1.0 - initial release
//============================================================================
module tb_axi_ram_responder;
    import axi_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    axi_ram_responder_if bus ();

    axi_ram_responder #(.MEM_AW(16), .RD_LAT(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;
    logic [31:0] wbuf [16];
    logic [31:0] rexp [16];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic axi_write(input string tag, input logic [3:0] id, input logic [31:0] addr,
                             input logic [7:0] len, input logic [1:0] burst, input logic [3:0] strb,
                             input int last_at, input int bdelay, input logic [1:0] exp_resp);
        int n;
        bus.awid = id; bus.awaddr = addr; bus.awlen = len; bus.awsize = 3'd2;
        bus.awburst = burst; bus.awvalid = 1'b1;
        n = 0;
        while (!bus.awready && n < 50) begin tick(); n++; end
        check({tag, " awready"}, 32'(bus.awready), 32'd1);
        tick();
        bus.awvalid = 1'b0;
        check({tag, " wready"}, 32'(bus.wready), 32'd1);
        for (int i = 0; i <= int'(len); i++) begin
            bus.wdata = wbuf[i]; bus.wstrb = strb; bus.wlast = (i == last_at); bus.wvalid = 1'b1;
            n = 0;
            while (!bus.wready && n < 50) begin tick(); n++; end
            tick();
        end
        bus.wvalid = 1'b0; bus.wlast = 1'b0;
        check({tag, " bvalid"}, 32'(bus.bvalid), 32'd1);
        check({tag, " bid"}, 32'(bus.bid), 32'(id));
        check({tag, " bresp"}, 32'(bus.bresp), 32'(exp_resp));
        for (int k = 0; k < bdelay; k++) begin
            tick();
            check({tag, " bvalid held"}, 32'(bus.bvalid), 32'd1);
            check({tag, " awready low"}, 32'(bus.awready), 32'd0);
        end
        bus.bready = 1'b1;
        tick();
        bus.bready = 1'b0;
        check({tag, " bvalid clear"}, 32'(bus.bvalid), 32'd0);
        check({tag, " awready back"}, 32'(bus.awready), 32'd1);
    endtask

    task automatic axi_read(input string tag, input logic [3:0] id, input logic [31:0] addr,
                            input logic [7:0] len, input logic [1:0] burst,
                            input bit stall, input bit chk_lat);
        int n;
        logic [31:0] held;
        bus.arid = id; bus.araddr = addr; bus.arlen = len; bus.arsize = 3'd2;
        bus.arburst = burst; bus.arvalid = 1'b1;
        n = 0;
        while (!bus.arready && n < 50) begin tick(); n++; end
        check({tag, " arready"}, 32'(bus.arready), 32'd1);
        tick();
        bus.arvalid = 1'b0;
        if (chk_lat) begin
            check({tag, " rvalid T+1"}, 32'(bus.rvalid), 32'd0);
            tick();
            check({tag, " rvalid T+2"}, 32'(bus.rvalid), 32'd0);
            tick();
            check({tag, " rvalid T+3"}, 32'(bus.rvalid), 32'd1);
        end
        bus.rready = !stall;
        for (int i = 0; i <= int'(len); i++) begin
            n = 0;
            while (!bus.rvalid && n < 50) begin tick(); n++; end
            check({tag, " rvalid"}, 32'(bus.rvalid), 32'd1);
            if (stall) begin
                held = bus.rdata;
                tick();
                check({tag, " rvalid stalled"}, 32'(bus.rvalid), 32'd1);
                check({tag, " rdata stalled"}, bus.rdata, held);
                bus.rready = 1'b1;
            end
            check({tag, " rdata"}, bus.rdata, rexp[i]);
            check({tag, " rid"}, 32'(bus.rid), 32'(id));
            check({tag, " rlast"}, 32'(bus.rlast), 32'(i == int'(len)));
            tick();
            if (stall) bus.rready = 1'b0;
        end
        bus.rready = 1'b0;
        check({tag, " rvalid done"}, 32'(bus.rvalid), 32'd0);
        check({tag, " arready back"}, 32'(bus.arready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "simulation did not finish");
    end

    initial begin
        reset = 1'b1;
        bus.arid = '0; bus.araddr = '0; bus.arlen = '0; bus.arsize = '0; bus.arburst = '0;
        bus.arlock = '0; bus.arcache = '0; bus.arprot = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
        bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awsize = '0; bus.awburst = '0;
        bus.awlock = '0; bus.awcache = '0; bus.awprot = '0; bus.awvalid = 1'b0;
        bus.wid = '0; bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0;
        bus.bready = 1'b0;

        // Reset held three cycles
        tick(); tick(); tick();
        check("rst ctrl", 32'({bus.arready, bus.awready, bus.rvalid, bus.rlast, bus.wready, bus.bvalid}), 32'd0);
        check("rst ids", 32'({bus.rid, bus.bid, bus.rresp, bus.bresp}), 32'd0);
        check("rst rdata", bus.rdata, 32'd0);
        reset = 1'b0;
        tick();
        check("post rst arready", 32'(bus.arready), 32'd1);
        check("post rst awready", 32'(bus.awready), 32'd1);

        // Single read with latency check
        wbuf[0] = 32'hDEADBEEF;
        axi_write("pre10", 4'd1, 32'h10, 8'd0, BURST_INCR, 4'hF, 0, 0, RESP_OKAY);
        rexp[0] = 32'hDEADBEEF;
        axi_read("rd10", 4'd1, 32'h10, 8'd0, BURST_INCR, 1'b0, 1'b1);

        // Cache line fill then WRAP refill starting at 0x18
        for (int i = 0; i < 8; i++) wbuf[i] = 32'hA000_0000 + 32'(i);
        axi_write("line0", 4'd2, 32'h00, 8'd7, BURST_INCR, 4'hF, 7, 0, RESP_OKAY);
        rexp[0] = 32'hA000_0006; rexp[1] = 32'hA000_0007;
        for (int i = 0; i < 6; i++) rexp[i+2] = 32'hA000_0000 + 32'(i);
        axi_read("wrap", 4'd0, 32'h18, 8'd7, BURST_WRAP, 1'b0, 1'b0);

        // FIXED burst: both beats land on one word, both read beats return it
        wbuf[0] = 32'h5555_0001; wbuf[1] = 32'h5555_0002;
        axi_write("fixed", 4'd3, 32'h30, 8'd1, BURST_FIXED, 4'hF, 1, 0, RESP_OKAY);
        rexp[0] = 32'h5555_0002; rexp[1] = 32'h5555_0002;
        axi_read("rdfixed", 4'd3, 32'h30, 8'd1, BURST_FIXED, 1'b0, 1'b0);

        // Partial write via byte strobes
        wbuf[0] = 32'h1122_3344;
        axi_write("full20", 4'd4, 32'h20, 8'd0, BURST_INCR, 4'hF, 0, 0, RESP_OKAY);
        wbuf[0] = 32'hAABB_CCDD;
        axi_write("part20", 4'd1, 32'h20, 8'd0, BURST_INCR, 4'b0101, 0, 0, RESP_OKAY);
        rexp[0] = 32'h11BB_33DD;
        axi_read("rd20", 4'd9, 32'h20, 8'd0, BURST_INCR, 1'b0, 1'b0);

        // WRAP with 3 beats is not a legal wrap length: steps as INCR
        rexp[0] = 32'hA000_0006; rexp[1] = 32'hA000_0007; rexp[2] = 32'h11BB_33DD;
        axi_read("wrap3", 4'd10, 32'h18, 8'd2, BURST_WRAP, 1'b0, 1'b0);

        // Back-pressure on B and R
        for (int i = 0; i < 4; i++) wbuf[i] = 32'hB000_0000 + 32'(i);
        axi_write("bp_w", 4'd5, 32'h80, 8'd3, BURST_INCR, 4'hF, 3, 5, RESP_OKAY);
        for (int i = 0; i < 4; i++) rexp[i] = 32'hB000_0000 + 32'(i);
        axi_read("bp_r", 4'd5, 32'h80, 8'd3, BURST_INCR, 1'b1, 1'b0);

        // Concurrent line write at 0x40 and read of 0x80
        for (int i = 0; i < 8; i++) wbuf[i] = 32'hC000_0000 + 32'(i);
        fork
            axi_write("cc_w", 4'd6, 32'h40, 8'd7, BURST_INCR, 4'hF, 7, 0, RESP_OKAY);
            axi_read("cc_r", 4'd7, 32'h80, 8'd3, BURST_INCR, 1'b0, 1'b0);
        join
        for (int i = 0; i < 5; i++) rexp[i] = 32'hC000_0003 + 32'(i);
        for (int i = 0; i < 3; i++) rexp[i+5] = 32'hC000_0000 + 32'(i);
        axi_read("cc_chk", 4'd11, 32'h4C, 8'd7, BURST_WRAP, 1'b0, 1'b0);

        // Early wlast on beat 3 of 4: burst still runs 4 beats, response SLVERR
        for (int i = 0; i < 4; i++) wbuf[i] = 32'hD000_0000 + 32'(i);
        axi_write("early", 4'd8, 32'h60, 8'd3, BURST_INCR, 4'hF, 2, 0, RESP_SLVERR);
        for (int i = 0; i < 4; i++) rexp[i] = 32'hD000_0000 + 32'(i);
        axi_read("rd60", 4'd12, 32'h60, 8'd3, BURST_INCR, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
